regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port integer register file with write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-cycle core's two-read/one-write register file in the pipelined RISC-V core.
- Decode issues destination registers into the scoreboard.
- Writeback retires them.
- Hazard logic reads per-port busy flags to decide stalls.

## Interface

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, at least 2; register 0 is hardwired zero.
- NRD, 2, number of read ports, 1 to 4.
- BYPASS, 1, enables same-cycle write-to-read forwarding when 1.
- AW, $clog2(NREGS), address width; derived, never overridden.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rd_addr  in  NRD×AW  read addresses, one per port.
- rd_data  out  NRD×XLEN  read data; combinational.
- rd_busy  out  NRD  1 = register at rd_addr has a pending write; combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  AW  issued destination.
- flush  in  1  clears all busy bits synchronously; register contents are kept.
- busy_cnt  out  AW+1  number of registers currently pending; registered.

## Operation

- Reset (rst_n low, any time, including mid-operation) forces the following, effective immediately and held until release:
  - all registers to 0;
  - all busy bits to 0;
  - busy_cnt to 0.
- Writes:
  - On a clock edge with wr_en=1 and wr_addr≠0, the register is loaded with wr_data and its busy bit is cleared.
  - A write to address 0 is ignored in full: no data is stored and no busy change occurs.
- Issue:
  - On a clock edge with iss_en=1 and iss_addr≠0, the busy bit is set.
  - An issue to address 0 is ignored.
  - Issuing an already-busy register keeps the bit at 1 and leaves busy_cnt unchanged.
- Simultaneous wr_en and iss_en to the same nonzero address: issue wins (a newer producer exists). Data is written and the busy bit stays 1.
- Reads:
  - rd_data[i] = 0 when rd_addr[i] = 0.
  - When BYPASS=1 and wr_en=1 and wr_addr = rd_addr[i] ≠ 0, rd_data[i] = wr_data.
  - Otherwise rd_data[i] = the stored value.
- rd_busy[i]:
  - Equals busy[rd_addr[i]].
  - When BYPASS=1, it is additionally forced to 0 when a qualifying same-cycle write to that address is present.
  - A same-cycle issue never affects rd_busy.
- flush:
  - Takes priority over issue and write clears: after the edge all busy bits are 0 and busy_cnt is 0.
  - A concurrent write still updates data.
- busy_cnt:
  - Tracks the number of set busy bits after each edge.
  - It is maintained incrementally: +1 on a new set, −1 on a clear of a set bit, net 0 when both happen to different registers.
  - Maximum value is NREGS−1 and it never wraps.

## Timing

- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency is 1 cycle: the stored value is visible on the non-bypassed path the cycle after the edge.
- Issue-to-busy latency is 1 cycle.
- The reset deassertion edge has no special sequencing. The first edge after release may issue or write.

## Structure

- Shared package regfile_pkg holds:
  - default XLEN and NREGS constants;
  - the ZERO_REG address constant;
  - an addr_t typedef built from AW.
- Sub-module regfile_scoreboard holds the busy bit vector, the issue/clear/flush priority logic and busy_cnt. It is parametrised by NREGS.
- The top level holds:
  - the register array;
  - write logic;
  - NRD generated read/bypass muxes.

## Test plan

- Reset mid-run: write x5=0xDEADBEEF, issue x6, pulse rst_n low between edges.
  - Required: rd_data for x5 reads 0 immediately, rd_busy for x6 = 0, busy_cnt = 0.
- Bypass: with BYPASS=1, wr_en on x3=0x12345678 and rd_addr[0]=x3 in the same cycle.
  - Required: rd_data[0]=0x12345678 that cycle.
  - Rerun with BYPASS=0: old value 0 is read, then 0x12345678 the next cycle.
- Scoreboard: issue x7, then x9.
  - Required: busy_cnt goes 1 then 2, rd_busy=1 for both.
  - Writeback x7: busy_cnt=1 and x7 is not busy.
- Same-address collision: iss_en and wr_en both on x4 with data 0xA5.
  - Required: x4 reads 0xA5, rd_busy stays 1, busy_cnt increments by 1.
- Zero register: write 0xFFFFFFFF to x0 and issue x0.
  - Required: all read ports addressing x0 return 0, rd_busy=0, busy_cnt unchanged.
- Flush: issue x1, x2, x3, then flush with a concurrent write x2=0x55.
  - Required: busy_cnt=0, all busy bits clear, x2 reads 0x55.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice: default sizing, the
// hardwired-zero register address and an address type for the default size.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    // Register 0 always reads zero and never becomes pending.
    localparam int unsigned ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   iss_en, iss_addr    issue: mark destination pending
//   clr_en, clr_addr    writeback: clear pending bit
//   flush               clear every busy bit (wins over issue and clear)
//   busy                busy bit vector (bit 0 always 0)
//   busy_cnt            number of set busy bits, registered
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             iss_v, clr_v, set_new, clr_old;

    always_comb begin
        iss_v   = iss_en && (iss_addr != AW'(ZERO_REG));
        clr_v   = clr_en && (clr_addr != AW'(ZERO_REG));
        set_new = iss_v && !busy_q[iss_addr];
        // A clear to the register being issued this cycle is overridden.
        clr_old = clr_v && busy_q[clr_addr] && !(iss_v && (iss_addr == clr_addr));

        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (clr_v) busy_d[clr_addr] = 1'b0;
            if (iss_v) busy_d[iss_addr] = 1'b1;
            cnt_d = cnt_q + CW'(set_new) - CW'(clr_old);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with optional write-to-read bypass
// and a pending-write scoreboard for pipeline hazard detection.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rd_addr / rd_data / rd_busy NRD packed read ports (port i at slice i)
//   wr_en, wr_addr, wr_data     writeback; clears the pending bit
//   iss_en, iss_addr            issue; marks the destination pending
//   flush                       clears all pending bits, data kept
//   busy_cnt                    number of pending registers, registered
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
    logic [NREGS-1:0]           busy;
    logic                       wr_v;

    assign wr_v = wr_en && (wr_addr != AW'(ZERO_REG));

    always_comb begin
        mem_d = mem_q;
        if (wr_v) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rd_addr[i*AW +: AW];
        // wr_v already excludes x0, so a hit implies a nonzero address.
        assign hit  = (BYPASS != 0) && wr_v && (wr_addr == addr);

        assign rd_data[i*XLEN +: XLEN] = (addr == AW'(ZERO_REG)) ? '0      :
                                         hit                     ? wr_data :
                                                                   mem_q[addr];
        // busy[0] is never set, so x0 needs no special case here.
        assign rd_busy[i] = hit ? 1'b0 : busy[addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         busy_cnt_b, busy_cnt_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: register values and pending flags.
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (byp && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply the edge rules to the reference state using the held inputs.
    task automatic model_update();
        if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*AW +: AW];
            check({tag, " rd_data byp"},   64'(rd_data_b[i*XLEN +: XLEN]), 64'(exp_rd(1'b1, a)));
            check({tag, " rd_data nobyp"}, 64'(rd_data_n[i*XLEN +: XLEN]), 64'(exp_rd(1'b0, a)));
            check({tag, " rd_busy byp"},   64'(rd_busy_b[i]), 64'(exp_busy(1'b1, a)));
            check({tag, " rd_busy nobyp"}, 64'(rd_busy_n[i]), 64'(exp_busy(1'b0, a)));
        end
        check({tag, " busy_cnt byp"},   64'(busy_cnt_b), 64'(m_count()));
        check({tag, " busy_cnt nobyp"}, 64'(busy_cnt_n), 64'(m_count()));
    endtask

    // Inputs are set just after a rising edge; check mid-cycle, then clock.
    task automatic tick(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(5'd0, 5'd1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset busy_cnt", 64'(busy_cnt_b), 64'd0);
        rst_n = 1'b1;

        // Bypass: same-cycle forwarding only in the BYPASS=1 instance.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234_5678;
        set_rd(5'd3, 5'd3);
        #1;
        check("bypass same cycle", 64'(rd_data_b[XLEN-1:0]), 64'h1234_5678);
        check("nobypass old value", 64'(rd_data_n[XLEN-1:0]), 64'h0);
        tick("bypass");
        idle();
        #1;
        check("nobypass next cycle", 64'(rd_data_n[XLEN-1:0]), 64'h1234_5678);

        // Scoreboard: issue x7, x9, then retire x7.
        set_rd(5'd7, 5'd9);
        iss_en = 1'b1; iss_addr = 5'd7;
        tick("iss x7");
        check("cnt after x7", 64'(busy_cnt_b), 64'd1);
        iss_addr = 5'd9;
        tick("iss x9");
        idle();
        #1;
        check("cnt after x9", 64'(busy_cnt_b), 64'd2);
        check("busy x7", 64'(rd_busy_b[0]), 64'd1);
        check("busy x9", 64'(rd_busy_b[1]), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7;
        tick("wb x7");
        idle();
        #1;
        check("cnt after wb x7", 64'(busy_cnt_b), 64'd1);
        check("x7 not busy", 64'(rd_busy_n[0]), 64'd0);

        // Collision: issue and write x4 together; issue wins.
        set_rd(5'd4, 5'd4);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5;
        iss_en = 1'b1; iss_addr = 5'd4;
        tick("collision");
        idle();
        #1;
        check("collision data", 64'(rd_data_n[XLEN-1:0]), 64'hA5);
        check("collision busy", 64'(rd_busy_b[0]), 64'd1);
        check("collision cnt", 64'(busy_cnt_b), 64'd2);

        // Zero register: writes and issues are ignored.
        set_rd(5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check("x0 bypass read", 64'(rd_data_b), 64'h0);
        tick("zero reg");
        idle();
        #1;
        check("x0 read", 64'(rd_data_b), 64'h0);
        check("x0 busy", 64'(rd_busy_b), 64'd0);
        check("x0 cnt", 64'(busy_cnt_b), 64'd2);

        // Flush with a concurrent write: busy cleared, data kept.
        set_rd(5'd2, 5'd3);
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1'b1; iss_addr = AW'(r);
            tick("flush prep");
        end
        idle();
        flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
        tick("flush");
        idle();
        #1;
        check("flush cnt", 64'(busy_cnt_b), 64'd0);
        check("flush busy", 64'(rd_busy_b), 64'd0);
        check("flush x2 data", 64'(rd_data_n[XLEN-1:0]), 64'h55);

        // Reset mid-run, asserted between edges.
        set_rd(5'd5, 5'd6);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd6;
        tick("pre reset");
        idle();
        #1;
        check("x5 before reset", 64'(rd_data_n[XLEN-1:0]), 64'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("x5 after reset", 64'(rd_data_n[XLEN-1:0]), 64'h0);
        check("x6 busy after reset", 64'(rd_busy_n[1]), 64'd0);
        check("cnt after reset", 64'(busy_cnt_n), 64'd0);
        #1;
        rst_n = 1'b1;
        tick("post reset");

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                idle();
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand reset");
                #1;
                rst_n = 1'b1;
            end
            wr_en    = ($urandom_range(0, 99) < 45);
            wr_addr  = AW'($urandom);
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 99) < 50);
            iss_addr = ($urandom_range(0, 9) == 0) ? wr_addr : AW'($urandom);
            flush    = ($urandom_range(0, 99) < 3);
            set_rd(($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom),
                   ($urandom_range(0, 3) == 0) ? iss_addr : AW'($urandom));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
